if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch stage placed directly upstream of the IF/ID register.
//  Owns the fetch PC and drives the instruction-memory req/ack handshake.
//  Buffers fetched {inst, pc+4} pairs in a small FIFO, so decode stalls (hazard
//  hold) do not block fetch. Flushes on a branch/jump redirect from EX/MEM.
// PARAMETERS
//  DEPTH     4    queue entries; power of two, >=2
//  RESET_PC  0    fetch PC after reset (32-bit)
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   reset, synchronous, active-high
//  imem_req       out  1   fetch request
//  imem_addr      out  32  byte address of the word requested; [1:0]=0
//  imem_ack       in   1   transfer completes in a cycle where req&&ack
//  imem_rdata     in   32  instruction word; valid when req&&ack
//  redirect_valid in   1   taken branch/jump: flush and refetch
//  redirect_pc    in   32  new fetch address; bits [1:0] ignored, forced to 0
//  id_ready       in   1   decode accepts the head entry this cycle (0 = stall)
//  if_valid       out  1   head entry present
//  if_inst        out  32  head instruction; 32'h0 (NOP) when !if_valid
//  if_pc_plus_4   out  32  head PC+4; 0 when !if_valid
//  q_count        out  $clog2(DEPTH)+1  occupancy, for debug/perf
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, q_count=0, if_valid=0, if_inst=0,
//    if_pc_plus_4=0, imem_req=0. Reset has priority over all other inputs.
//    Reset during an open request drops that request with no side effects.
//  - imem_req = !reset_cycle && !redirect_valid && (q_count < DEPTH).
//    imem_addr = fetch_pc. Req may deassert, or change address, before ack:
//    no transfer is outstanding until req&&ack.
//  - On req&&ack (no redirect): push {imem_rdata, fetch_pc+4}, fetch_pc+=4
//    (32-bit wrap, no error). The entry is visible on if_* next cycle
//    (1-cycle fill latency, no bypass from imem_rdata to outputs).
//  - Pop when if_valid && id_ready. Push and pop in the same cycle: count is
//    unchanged and the pointers both advance. Since req requires count<DEPTH,
//    the queue never overflows. Pop on empty cannot occur.
//  - Redirect (highest priority after reset): queue emptied, any same-cycle
//    pop and any same-cycle ack data discarded, fetch_pc={redirect_pc[31:2],2'b00}.
//    The first request to the new address is issued the next cycle.
//  - Back-to-back redirects: the last one wins. No state machine is needed
//    beyond the pointers, count and fetch_pc.
//  - Pointers wrap modulo DEPTH. q_count ranges 0..DEPTH inclusive.
//  - Outputs if_* are combinational from the head storage entry, gated by
//    if_valid.
// STRUCTURE
//  - Shared package pipeline_pkg: INST_NOP=32'h0, RESET_PC default,
//    typedef fetch_entry_t {inst[31:0], pc_plus_4[31:0]}.
//  - One sub-module: fetch_fifo (sync FIFO, DEPTH x 64b, with flush, push,
//    pop, count).
//  - Top level holds fetch_pc, request gating and redirect priority.
// TESTING
//  1. Reset 3 cycles, with imem_ack=1 -> imem_req=0 during reset, if_valid=0,
//     if_inst=0. After release: imem_addr=0, q_count=0.
//  2. Zero-wait imem (ack=1), id_ready=1, rdata=addr-based words -> if_inst
//     follows the 0,4,8.. words with 1-cycle lag; if_pc_plus_4=4,8,12...
//  3. id_ready=0 for 10 cycles -> q_count saturates at DEPTH=4, imem_req=0
//     with imem_addr=0x10 held. Raise id_ready -> order preserved, no loss
//     or duplicate.
//  4. redirect_valid=1, redirect_pc=0x0000_0103 with ack and pop in the same
//     cycle -> next cycle if_valid=0, q_count=0, imem_addr=0x100; the acked
//     word is never output.
//  5. imem_ack=0 for 3 cycles per request -> imem_addr stable while req held.
//     Exactly one push per req&&ack; the throughput matches the wait states.
//  6. Redirect on two consecutive cycles (0x40 then 0x80) -> the first fetch
//     is at 0x80. Reset asserted while q_count=3 -> empty next cycle, PC=RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch front end.
package pipeline_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus_4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {inst, pc+4} pairs with flush, push, pop and occupancy.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    // Flush wins over any same-cycle push or pop; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives imem req/ack, buffers fetched words for decode.
module if_prefetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       id_ready,
    output logic                       if_valid,
    output logic [31:0]                if_inst,
    output logic [31:0]                if_pc_plus_4,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push;
    logic         pop;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic [CW-1:0] count;

    // Never request while full, so the queue cannot overflow.
    assign imem_req  = !reset && !redirect_valid && (count < CW'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign push       = imem_req && imem_ack;
    assign pop        = if_valid && id_ready && !redirect_valid;
    assign push_entry = '{inst: imem_rdata, pc_plus_4: fetch_pc_q + 32'd4};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign if_valid     = (count != '0);
    assign if_inst      = if_valid ? head.inst      : INST_NOP;
    assign if_pc_plus_4 = if_valid ? head.pc_plus_4 : 32'h0;
    assign q_count      = count;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: vector table, directed corner sequences and a queue-based reference.
module tb_if_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc_plus_4;
    logic [2:0]  q_count;

    always #5 clock = ~clock;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc_plus_4   (if_pc_plus_4),
        .q_count        (q_count)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory returns an address-tagged word so ordering errors show up in if_inst.
    assign imem_rdata = word_at(imem_addr);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_entry_t;

    typedef struct {
        logic        rst, ack, redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [2:0]  e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_entry_t  sb[$];
    logic [31:0] m_pc;
    bit          m_known = 0;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_inst, obs_pc4;
    logic [2:0]  obs_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ack, input logic redir,
                        input logic [31:0] rpc, input logic rdy);
        logic        e_req, e_valid, pop_m, push_m;
        exp_entry_t  head;
        reset          = rst;
        imem_ack       = ack;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(negedge clock);
        obs_req = imem_req;  obs_addr = imem_addr; obs_valid = if_valid;
        obs_inst = if_inst;  obs_pc4 = if_pc_plus_4; obs_cnt = q_count;
        e_req   = !rst && !redir && (sb.size() < 4);
        e_valid = (sb.size() != 0);
        head    = e_valid ? sb[0] : '0;
        if (m_known) begin
            check("req",   {31'b0, obs_req},   {31'b0, e_req});
            check("addr",  obs_addr,           m_pc);
            check("valid", {31'b0, obs_valid}, {31'b0, e_valid});
            check("inst",  obs_inst,           head.inst);
            check("pc4",   obs_pc4,            head.pc4);
            check("count", {29'b0, obs_cnt},   sb.size());
        end
        if (rst) begin
            sb.delete();
            m_pc    = 32'h0;
            m_known = 1;
        end else if (redir) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            pop_m  = e_valid && rdy;
            push_m = e_req && ack;
            if (pop_m) void'(sb.pop_front());
            if (push_m) begin
                sb.push_back('{inst: word_at(m_pc), pc4: m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         3'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h5A5A_0000, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h5A5A_0004, 3'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h5A5A_0008, 3'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h5A5A_0008, 3'd2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0014, 1'b1, 32'h5A5A_0008, 3'd3};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0018, 1'b1, 32'h5A5A_0008, 3'd4};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0000_0018, 1'b1, 32'h5A5A_0008, 3'd4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         3'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h5A5A_0100, 3'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0,         3'd0};

        reset = 1'b1; imem_ack = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        @(posedge clock);
        #1;

        // Three reset cycles with ack held high: no request may appear.
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_req", {31'b0, obs_req}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].ack, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            check($sformatf("t%0d_req", i),   {31'b0, obs_req},   {31'b0, tbl[i].e_req});
            check($sformatf("t%0d_addr", i),  obs_addr,           tbl[i].e_addr);
            check($sformatf("t%0d_valid", i), {31'b0, obs_valid}, {31'b0, tbl[i].e_valid});
            check($sformatf("t%0d_inst", i),  obs_inst,           tbl[i].e_inst);
            check($sformatf("t%0d_cnt", i),   {29'b0, obs_cnt},   {29'b0, tbl[i].e_cnt});
        end

        // Decode stall long enough to fill the queue, then drain in order.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full_cnt", {29'b0, obs_cnt}, 32'd4);
        check("full_req", {31'b0, obs_req}, 32'd0);
        check("full_addr", obs_addr, 32'h0000_0114);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Three wait states per request.
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 3; w++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        end

        // Redirect coinciding with ack and pop: acked word must be dropped.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("redir_valid", {31'b0, obs_valid}, 32'd0);
        check("redir_cnt", {29'b0, obs_cnt}, 32'd0);
        check("redir_addr", obs_addr, 32'h0000_0100);

        // Back-to-back redirects: the later one wins.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("b2b_addr", obs_addr, 32'h0000_0080);
        check("b2b_req", {31'b0, obs_req}, 32'd1);

        // PC wraps past the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_pc4", obs_pc4, 32'h0);
        check("wrap_addr", obs_addr, 32'h0);

        // Reset while three entries are queued.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("pre_rst_cnt", {29'b0, obs_cnt}, 32'd3);
        check("rst_req_open", {31'b0, obs_req}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("post_rst_cnt", {29'b0, obs_cnt}, 32'd0);
        check("post_rst_addr", obs_addr, 32'h0);
        check("post_rst_valid", {31'b0, obs_valid}, 32'd0);

        // Randomised traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), ($urandom_range(15) == 0),
                 $urandom, $urandom_range(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
